// File: rtl/param_core_pkg.sv
// rtl/param_core_pkg.sv - opcodes, field positions, state enum and flag indices for param_core
package param_core_pkg;

  localparam logic [4:0] OP_MOVSGPR   = 5'b00000;
  localparam logic [4:0] OP_MOV       = 5'b00001;
  localparam logic [4:0] OP_ADD       = 5'b00010;
  localparam logic [4:0] OP_SUB       = 5'b00011;
  localparam logic [4:0] OP_MUL       = 5'b00100;
  localparam logic [4:0] OP_OR        = 5'b00101;
  localparam logic [4:0] OP_AND       = 5'b00110;
  localparam logic [4:0] OP_NOT       = 5'b00111;
  localparam logic [4:0] OP_NAND      = 5'b01000;
  localparam logic [4:0] OP_NOR       = 5'b01001;
  localparam logic [4:0] OP_XOR       = 5'b01010;
  localparam logic [4:0] OP_XNOR      = 5'b01011;
  localparam logic [4:0] OP_STOREREG  = 5'b01100;
  localparam logic [4:0] OP_STOREDIN  = 5'b01101;
  localparam logic [4:0] OP_SEND2DOUT = 5'b01110;
  localparam logic [4:0] OP_SEND2REG  = 5'b01111;
  localparam logic [4:0] OP_JUMP      = 5'b10010;
  localparam logic [4:0] OP_JC        = 5'b10011;
  localparam logic [4:0] OP_JNC       = 5'b10100;
  localparam logic [4:0] OP_JS        = 5'b10101;
  localparam logic [4:0] OP_JNS       = 5'b10110;
  localparam logic [4:0] OP_JZ        = 5'b10111;
  localparam logic [4:0] OP_JNZ       = 5'b11000;
  localparam logic [4:0] OP_JV        = 5'b11001;
  localparam logic [4:0] OP_JNV       = 5'b11010;
  localparam logic [4:0] OP_HALT      = 5'b11011;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 27;
  localparam int RDST_MSB  = 26;
  localparam int RDST_LSB  = 22;
  localparam int RSRC1_MSB = 21;
  localparam int RSRC1_LSB = 17;
  localparam int MODE_BIT  = 16;
  localparam int RSRC2_MSB = 15;
  localparam int RSRC2_LSB = 11;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT_DIN, HALT} state_t;

  // flags_o = {overflow, carry, zero, sign}
  localparam int FLAG_SIGN  = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;

  function automatic logic is_flag_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
           ((op >= OP_OR) && (op <= OP_XNOR));
  endfunction

endpackage

// File: rtl/param_core_alu.sv
// rtl/param_core_alu.sv - combinational ALU: result, high product half and next flags
module param_core_alu
  import param_core_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [4:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic [DW-1:0] hi,
  output logic          sign,
  output logic          zero,
  output logic          carry,
  output logic          overflow
);

  logic [DW:0]     sum;
  logic [DW:0]     diff;
  logic [2*DW-1:0] prod;

  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    prod     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    result   = '0;
    hi       = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_MOV:  result = b;
      OP_ADD: begin
        result   = sum[DW-1:0];
        carry    = sum[DW];
        overflow = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        result   = diff[DW-1:0];
        carry    = diff[DW];
        overflow = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
      OP_MUL: begin
        result = prod[DW-1:0];
        hi     = prod[2*DW-1:DW];
      end
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_NOT:  result = ~a;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      default: result = '0;
    endcase
    // mul reports sign/zero on the full double-width product
    sign = (op == OP_MUL) ? prod[2*DW-1] : result[DW-1];
    zero = (op == OP_MUL) ? (prod == '0) : (result == '0);
  end

endmodule

// File: rtl/param_core.sv
// rtl/param_core.sv - multi-cycle FETCH/EXEC core with GPRs, imem/dmem and din/dout handshakes
// Optional 32-bit retire counter output when PARAM_CORE_RETIRE_CNT_EN is defined.
module param_core
  import param_core_pkg::*;
#(
  parameter  int DW         = 16,
  parameter  int NREG       = 32,
  parameter  int IMEM_DEPTH = 16,
  parameter  int DMEM_DEPTH = 16,
  localparam int PW         = $clog2(IMEM_DEPTH),
  localparam int AW         = $clog2(DMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          prog_we,
  input  logic [PW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          halted,
  output logic [PW-1:0] pc_o,
  output logic [3:0]    flags_o
`ifdef PARAM_CORE_RETIRE_CNT_EN
  ,
  output logic [31:0]   retire_cnt
`endif
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  state_t        state, next_state;
  logic [31:0]   imem [IMEM_DEPTH];
  logic [DW-1:0] dmem [DMEM_DEPTH];
  logic [DW-1:0] gpr  [NREG];
  logic [31:0]   ir;
  logic [PW-1:0] pc;
  logic [DW-1:0] sgpr;
  logic [3:0]    flags;

  logic [4:0]    op, rdst, rsrc1, rsrc2;
  logic          mode;
  logic [DW-1:0] imm, rs1_val, rs2_val, opa, opb, alu_res, alu_hi, wr_data;
  logic [AW-1:0] daddr;
  logic [PW-1:0] target;
  logic          f_sign, f_zero, f_carry, f_ovf;
  logic          ctrl_start, exec_commit, din_xfer, taken, wr_en;

  function automatic logic [DW-1:0] rd_gpr(input logic [4:0] idx);
    if (int'(idx) < NREG) return gpr[idx[RW-1:0]];
    return '0;
  endfunction

  assign op      = ir[OP_MSB:OP_LSB];
  assign rdst    = ir[RDST_MSB:RDST_LSB];
  assign rsrc1   = ir[RSRC1_MSB:RSRC1_LSB];
  assign mode    = ir[MODE_BIT];
  assign rsrc2   = ir[RSRC2_MSB:RSRC2_LSB];
  assign imm     = DW'(ir[IMM_MSB:IMM_LSB]);
  assign daddr   = ir[AW-1:0];
  assign target  = ir[PW-1:0];
  assign rs1_val = rd_gpr(rsrc1);
  assign rs2_val = rd_gpr(rsrc2);
  assign opb     = mode ? imm : rs2_val;
  // not with mode=1 inverts the immediate, so it rides in on operand A
  assign opa     = (op == OP_NOT && mode) ? imm : rs1_val;

  param_core_alu #(.DW(DW)) u_alu (
    .op       (op),
    .a        (opa),
    .b        (opb),
    .result   (alu_res),
    .hi       (alu_hi),
    .sign     (f_sign),
    .zero     (f_zero),
    .carry    (f_carry),
    .overflow (f_ovf)
  );

  always_comb begin
    case (op)
      OP_JUMP: taken = 1'b1;
      OP_JC:   taken = flags[FLAG_CARRY];
      OP_JNC:  taken = !flags[FLAG_CARRY];
      OP_JS:   taken = flags[FLAG_SIGN];
      OP_JNS:  taken = !flags[FLAG_SIGN];
      OP_JZ:   taken = flags[FLAG_ZERO];
      OP_JNZ:  taken = !flags[FLAG_ZERO];
      OP_JV:   taken = flags[FLAG_OVF];
      OP_JNV:  taken = !flags[FLAG_OVF];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_data = alu_res;
    case (op)
      OP_MOVSGPR: begin wr_en = 1'b1; wr_data = sgpr;        end
      OP_SEND2REG: begin wr_en = 1'b1; wr_data = dmem[daddr]; end
      OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_NOT,
      OP_NAND, OP_NOR, OP_XOR, OP_XNOR: wr_en = 1'b1;
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    din_ready   = 1'b0;
    ctrl_start  = 1'b0;
    exec_commit = 1'b0;
    din_xfer    = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          ctrl_start = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH: next_state = EXEC;
      EXEC: begin
        if (op == OP_STOREDIN) begin
          din_ready = 1'b1;
          if (din_valid) begin
            din_xfer    = 1'b1;
            exec_commit = 1'b1;
            next_state  = FETCH;
          end else begin
            next_state = WAIT_DIN;
          end
        end else begin
          exec_commit = 1'b1;
          next_state  = (op == OP_HALT) ? HALT : FETCH;
        end
      end
      WAIT_DIN: begin
        din_ready = 1'b1;
        if (din_valid) begin
          din_xfer    = 1'b1;
          exec_commit = 1'b1;
          next_state  = FETCH;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      ir         <= '0;
      sgpr       <= '0;
      flags      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else begin
      dout_valid <= 1'b0;
      if (ctrl_start) pc <= '0;
      if (state == FETCH) ir <= imem[pc];
      if (exec_commit) begin
        if (op != OP_HALT) pc <= taken ? target : pc + PW'(1);
        if (wr_en && int'(rdst) < NREG) gpr[rdst[RW-1:0]] <= wr_data;
        if (op == OP_MUL) sgpr <= alu_hi;
        if (is_flag_op(op)) flags <= {f_ovf, f_carry, f_zero, f_sign};
        if (op == OP_SEND2DOUT) begin
          dout       <= dmem[daddr];
          dout_valid <= 1'b1;
        end
      end
    end
  end

  // program loads only land while the core is parked
  always_ff @(posedge clk) begin
    if (prog_we && (state == IDLE || state == HALT)) imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (exec_commit && op == OP_STOREREG) dmem[daddr] <= rs1_val;
    if (din_xfer) dmem[daddr] <= din;
  end

`ifdef PARAM_CORE_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   retire_cnt <= '0;
    else if (ctrl_start)                       retire_cnt <= '0;
    else if (exec_commit && retire_cnt != '1)  retire_cnt <= retire_cnt + 32'd1;
  end
`endif

  assign busy    = (state == FETCH) || (state == EXEC) || (state == WAIT_DIN);
  assign halted  = (state == HALT);
  assign pc_o    = pc;
  assign flags_o = flags;

endmodule

// File: doc/param_core.md
Name: param_core

Overview:
- Parametrised multi-cycle successor of the team's 16-bit 5-bit-opcode processor.
- Width, register count and memory depths are generics.
- Program memory is loaded at run time; a start/halt handshake controls execution.
- Flags are registered; din and dout use a valid/ready handshake; instructions take a fixed 2-cycle FETCH/EXEC sequence.
- Sits at top level between the host loader and the I/O bus.

Parameters:
- DW, 16, datapath/GPR/data-memory word width (8..32).
- NREG, 32, number of GPRs (2..32). Register index fields stay 5 bits.
- IMEM_DEPTH, 16, instruction words (power of 2). PW = clog2(IMEM_DEPTH).
- DMEM_DEPTH, 16, data words (power of 2). AW = clog2(DMEM_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin execution at pc=0; honoured only in IDLE or HALT
- prog_we  in  1  instruction-memory write strobe; honoured only in IDLE or HALT
- prog_addr  in  PW  instruction write address
- prog_data  in  32  instruction word
- din  in  DW  input data
- din_valid  in  1  din holds valid data
- din_ready  out  1  core consumes din this cycle
- dout  out  DW  output data; holds its value between sends
- dout_valid  out  1  one-cycle strobe, dout updated
- busy  out  1  state is FETCH, EXEC or WAIT_DIN
- halted  out  1  state is HALT
- pc_o  out  PW  current pc
- flags_o  out  4  {overflow, carry, zero, sign}

Behaviour:
- Encoding: op=IR[31:27], rdst=[26:22], rsrc1=[21:17], mode=[16], rsrc2=[15:11], imm=[15:0].
- Immediate is zero-extended or truncated to DW.
- Operand B is imm when mode=1, else GPR[rsrc2].
- Opcodes:
  - 00000 movsgpr, 00001 mov, 00010 add, 00011 sub, 00100 mul.
  - 00101 or, 00110 and, 00111 not, 01000 nand, 01001 nor, 01010 xor, 01011 xnor.
  - 01100 storereg: dmem[imm] <= GPR[rsrc1].
  - 01101 storedin: dmem[imm] <= din.
  - 01110 send2dout, 01111 send2reg.
  - 10010 jump; 10011..11010 conditional jumps: carry, nocarry, sign, nosign, zero, nozero, overflow, nooverflow.
  - 11011 halt.
  - Any other opcode is a NOP.
- not with mode=0 inverts GPR[rsrc1]; with mode=1 it inverts imm.
- Register index >= NREG: reads return 0; writes are dropped.
- Data address is imm[AW-1:0]; jump target is imm[PW-1:0].
- Reset (async): state=IDLE, pc=0, IR=0, GPR/SGPR/flags=0, dout=0, all strobes 0. Memory contents are not reset.
- FSM:
  - IDLE: start -> FETCH with pc=0.
  - FETCH: IR <= imem[pc]; -> EXEC.
  - EXEC:
    - Commit the result.
    - pc <= taken ? target : pc+1, wrapping mod IMEM_DEPTH.
    - -> FETCH, or HALT for the halt opcode (pc not advanced).
    - storedin with din_valid=0 -> WAIT_DIN.
  - WAIT_DIN: din_ready=1; when din_valid=1, write dmem, advance pc, -> FETCH.
  - HALT: start -> FETCH with pc=0.
- Cycles per instruction: 2 (FETCH + EXEC). storedin takes 2 + stall cycles.
- din_ready is high combinationally in EXEC and WAIT_DIN when op=storedin. The transfer completes on din_valid & din_ready.
- send2dout: dout <= dmem[addr]; dout_valid=1 for the cycle after EXEC.
- mul: 2DW-bit product P; GPR[rdst] <= P[DW-1:0]; SGPR <= P[2DW-1:DW].
- movsgpr: GPR[rdst] <= SGPR.
- Flags are updated only by add, sub, mul and the logic ops; all other opcodes hold them. Values are computed from pre-write operands.
  - sign = result MSB (mul: P MSB).
  - zero = result==0 (mul: P==0).
  - carry = add carry-out / sub borrow; 0 for others.
  - overflow = signed add/sub overflow; 0 for others.
- Same-instruction read/write of one register uses the old value; the written value is visible to the next instruction.
- prog_we while busy is ignored.
- start and prog_we in the same cycle: the write takes effect first and the fetch sees the new word.

Optional Feature:
- Macro PARAM_CORE_RETIRE_CNT_EN.
- Defined: adds output retire_cnt (32 bits). It resets to 0, increments on every completed EXEC/WAIT_DIN commit including halt, saturates at all-ones, and clears on start.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package param_core_pkg holds:
  - opcode localparams;
  - field bit-position constants;
  - state enum {IDLE, FETCH, EXEC, WAIT_DIN, HALT};
  - flag index constants.
- One sub-module param_core_alu: combinational. Inputs op, A, B. Outputs result, hi, and the four next-flags.
- The FSM, register file and memories live in param_core.

Test Plan:
- Load mov r1,#5; add r2,r1,#7; storereg [3],r2; send2dout [3]; halt; then start. Expect dout=12 with one dout_valid pulse, halted=1 in the 11th cycle after start, and flags 0000.
- DW=16: add r1=0x7FFF + #1. Expect r1=0x8000, overflow=1, sign=1, carry=0. Then add 0xFFFF+#1: r=0, carry=1, zero=1.
- mul 0x1234*0x0100 then movsgpr r3. Expect r=0x3400, SGPR=0x0012, r3=0x0012.
- storedin with din_valid held low 5 cycles, then din=0xABCD for 1 cycle. Expect busy held and pc frozen for 5 cycles; din_ready high throughout; dmem=0xABCD.
- jnozero to pc 15, then fall through with IMEM_DEPTH=16. Expect pc 15 -> 0 wrap. prog_we during busy leaves imem unchanged.
- rst asserted mid-EXEC. Expect immediate IDLE, GPR=0, dout=0, no dout_valid. imem program survives and reruns after start.
